// File: rtl/enc_seq_ctrl_if.sv
// Command channel for enc_seq_ctrl: valid/ready handshake carrying one motion command.
interface enc_seq_ctrl_if #(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0]  cmd_div;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, output cmd_div,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, input cmd_div,
                  output cmd_ready);
endinterface

// File: rtl/enc_seq_ctrl.sv
// Command-paced quadrature encoder sequencer (pha/phb/index/home/pos).
// Define ENC_SEQ_QUEUE_EN to place a 2-entry command FIFO in front of the FSM.
module enc_seq_ctrl #(
  parameter int CPR    = 100,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 24
) (
  input  logic                freq_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                abort,
  enc_seq_ctrl_if.slave       cmd,
  output logic                pha,
  output logic                phb,
  output logic                index,
  output logic                home,
  output logic [15:0]         pos,
  output logic                busy,
  output logic                done
);
  localparam logic [15:0] POS_MAX = 16'(CPR - 1);
  localparam int          ENT_W   = 1 + STEP_W + DIV_W;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [1:0]        q_q, q_d;
  logic [15:0]       pos_q, pos_d;
  logic              pha_q, phb_q, index_q, home_q, busy_q, done_q, ready_q;
  logic              busy_d, ready_d, load_s, step_s, accept_s, avail_s;
  logic [ENT_W-1:0]  in_ent_s, head_s;
  logic [STEP_W-1:0] head_steps_s;
  logic [DIV_W-1:0]  head_div_s;

  assign accept_s     = cmd.cmd_valid && ready_q;
  assign in_ent_s     = {cmd.cmd_dir, cmd.cmd_steps, cmd.cmd_div};
  assign head_steps_s = head_s[DIV_W +: STEP_W];
  assign head_div_s   = head_s[DIV_W-1:0];

`ifdef ENC_SEQ_QUEUE_EN
  logic [ENT_W-1:0] fifo_q [2];
  logic             wr_q, wr_d, rd_q, rd_d, push_s, pop_s, flush_s;
  logic [1:0]       cnt_q, cnt_d;

  // An empty FIFO lets a freshly accepted command bypass straight into the FSM.
  assign head_s  = (cnt_q != 2'd0) ? fifo_q[rd_q] : in_ent_s;
  assign avail_s = (cnt_q != 2'd0) || accept_s;

  // FIFO pointer/occupancy next state and handshake status
  always_comb begin
    flush_s = (state_q == ST_RUN) && abort;
    pop_s   = load_s && (cnt_q != 2'd0);
    push_s  = accept_s && !(load_s && (cnt_q == 2'd0));
    if (flush_s) begin
      cnt_d = 2'd0;
      wr_d  = 1'b0;
      rd_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
      wr_d  = wr_q ^ push_s;
      rd_d  = rd_q ^ pop_s;
    end
    ready_d = (cnt_d != 2'd2);
    busy_d  = (state_d != ST_IDLE) || (cnt_d != 2'd0);
  end

  // FIFO storage and pointers
  always_ff @(posedge freq_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      if (push_s && !flush_s) begin
        fifo_q[wr_q] <= in_ent_s;
      end
    end
  end
`else
  assign head_s  = in_ent_s;
  assign avail_s = accept_s;

  // Handshake status without a queue
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end
`endif

  // FSM next state, prescaler and quadrature/position stepping
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    div_d   = div_q;
    presc_d = presc_q;
    q_d     = q_q;
    pos_d   = pos_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avail_s) load_s = 1'b1;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        // abort wins over a coinciding terminal count; that step is dropped
        if (abort) begin
          state_d = ST_DONE;
        end else if (enable) begin
          if (presc_q == (div_q - DIV_W'(1))) begin
            step_s  = 1'b1;
            presc_d = '0;
            rem_d   = rem_q - STEP_W'(1);
            if (rem_q == STEP_W'(1)) state_d = ST_DONE;
            else                     state_d = ST_RUN;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (avail_s) load_s = 1'b1;
        else         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_s) begin
      dir_d   = head_s[ENT_W-1];
      rem_d   = head_steps_s;
      div_d   = (head_div_s == '0) ? DIV_W'(1) : head_div_s;
      presc_d = '0;
      state_d = (head_steps_s == '0) ? ST_DONE : ST_RUN;
    end else begin
      load_s = 1'b0;
    end

    if (step_s) begin
      if (dir_q) begin
        q_d   = q_q + 2'd1;
        pos_d = (pos_q == POS_MAX) ? 16'd0 : pos_q + 16'd1;
      end else begin
        q_d   = q_q - 2'd1;
        pos_d = (pos_q == 16'd0) ? POS_MAX : pos_q - 16'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers; all pin outputs are registered from next-state values
  always_ff @(posedge freq_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      div_q   <= DIV_W'(1);
      presc_q <= '0;
      q_q     <= 2'd0;
      pos_q   <= 16'd0;
      pha_q   <= 1'b0;
      phb_q   <= 1'b0;
      index_q <= 1'b1;
      home_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      q_q     <= q_d;
      pos_q   <= pos_d;
      pha_q   <= q_d[1] ^ q_d[0];
      phb_q   <= q_d[1];
      index_q <= (pos_d == 16'd0);
      home_q  <= (pos_d == 16'd0) || (pos_d == POS_MAX);
      busy_q  <= busy_d;
      done_q  <= (state_d == ST_DONE);
      ready_q <= ready_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign pha   = pha_q;
  assign phb   = phb_q;
  assign index = index_q;
  assign home  = home_q;
  assign pos   = pos_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: doc/enc_seq_ctrl.md
# enc_seq_ctrl

Command-driven sequencer for the quadrature encoder emulator outputs (pha/phb/index/home). It accepts motion commands (direction, step count, step period), paces them from freq_clk and drives the quadrature phase state and the position within a revolution. It sits between the board-level test controller and the encoder pins, so the encoder stimulus no longer free-runs at a fixed rate.

## Interface
- CPR, 100: quadrature counts per revolution; position wraps modulo CPR (2..65535).
- STEP_W, 16: width of cmd_steps.
- DIV_W, 24: width of cmd_div.
- freq_clk  in  1  sole clock (50 MHz board clock).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high: sequencer advances; low: prescaler and state frozen, outputs held.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted; transfer on cmd_valid && cmd_ready at a rising edge.
- cmd_dir  in  1  1 = forward (pha leads phb), 0 = reverse (phb leads pha).
- cmd_steps  in  STEP_W  number of quadrature edges to emit.
- cmd_div  in  DIV_W  freq_clk cycles per quadrature edge; 0 is treated as 1.
- abort  in  1  terminate the running command (and, with the queue, flush it).
- pha, phb  out  1  quadrature outputs.
- index  out  1  high while pos == 0.
- home  out  1  high while pos == 0 or pos == CPR-1.
- pos  out  16  position within revolution, 0..CPR-1.
- busy  out  1  state != IDLE, or a queued command is pending.
- done  out  1  one-cycle pulse when a command completes or is aborted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on accept, latch dir/steps/div, clear prescaler, go to RUN. If steps == 0, go to DONE instead; no edges are emitted.
- RUN, enable high: prescaler counts 0..div-1. At terminal count, emit one quadrature step and decrement remaining. On the step that brings remaining to 0, go to DONE.
- Quadrature state q (2 bits), encoded {pha,phb}: 0 = 00, 1 = 10, 2 = 11, 3 = 01.
  - Forward: q+1 mod 4, pos+1 with CPR-1 -> 0.
  - Reverse: q-1 mod 4, pos-1 with 0 -> CPR-1.
- Exactly one of pha/phb changes per step; no glitches.
- DONE: done = 1 for this single cycle, then IDLE.
- abort in RUN: next edge goes to DONE. pha, phb, pos and q hold their current values. abort in IDLE or DONE is ignored. abort has priority over a simultaneous terminal-count step; that step is not emitted.
- enable low: no prescaler count, no step, no state change. Command accept is still permitted. A DONE→IDLE transition still occurs.
- q and pos persist across commands; each new command continues from the current position.
- pha, phb, index, home and pos are all registered and update on the same edge.

## Timing
- Reset values: pha = 0, phb = 0, q = 0, pos = 0, index = 1, home = 1, busy = 0, done = 0, cmd_ready = 1, state IDLE, queue empty.
- Command accepted at edge T0 with enable held high: steps occur at edges T0 + k·div for k = 1..steps.
- done is high during the cycle after edge T0 + steps·div. cmd_ready (no queue) returns high one cycle later.
- Zero-step command: done is high during the cycle after T0.
- Reset asserted mid-run forces all reset values immediately (asynchronous).

## Configuration
- ENC_SEQ_QUEUE_EN defined: a 2-entry command FIFO sits in front of the state machine.
  - cmd_ready = !fifo_full.
  - In DONE with the FIFO non-empty, the head is loaded and RUN is entered directly, skipping IDLE.
  - Successive commands are separated by exactly one done cycle.
  - abort also flushes the FIFO.
- ENC_SEQ_QUEUE_EN undefined: no FIFO; cmd_ready = (state == IDLE).

## Test plan
- Reset: assert rst_n = 0 mid-run -> immediately pha = phb = 0, pos = 0, index = home = 1, busy = done = 0, cmd_ready = 1.
- Forward, steps = 8, div = 4, from reset -> {pha,phb} = 10, 11, 01, 00 twice, changing at T0+4, 8, …, 32. pos = 8; done high one cycle after T0+32; index low from T0+4 onward.
- Reverse, steps = 2, div = 1, from pos 0 -> pos goes to CPR-1 (99) then 98; {pha,phb} = 01 then 11; home = 1 at 99 and 0 at 98.
- Wrap, CPR = 100, forward, steps = 100, div = 2 -> index reasserts at T0+200 with pos = 0, q = 0; exactly one done pulse.
- Abort and freeze: steps = 1000, div = 10, abort asserted after the 5th step -> done on the next cycle, pos = 5, outputs hold. Separately, enable low for 50 cycles mid-run -> every edge thereafter is delayed by 50 cycles.
- With ENC_SEQ_QUEUE_EN: three back-to-back commands of steps = 3, div = 1 -> third cmd_ready low until the first command completes. 9 steps total, three done pulses each followed by the next first step one edge after the done cycle ends. Zero-step command -> done one cycle after accept, no edges.
